// File: rtl/fpga_mode_ctrl_if.sv
// SPI pins and mode-mux fan-out of fpga_mode_ctrl, grouped as one bundle.
//   master : ARM side; drives spck/mosi/ncs and observes the controller outputs
//   slave  : fpga_mode_ctrl side
// Signals:
//   spck, mosi, ncs  SPI clock, data and active-low chip select (asynchronous to pck0)
//   miso             status readback
//   major_mode       mode-mux select
//   conf_word        full configuration word; [7:5] mirrors major_mode
//   divisor          LF clock divisor
//   quiesce, busy    mux quiesce request / mode-switch sequence in progress
//   frame_err        one-cycle pulse on a dropped frame
interface fpga_mode_ctrl_if;
  logic       spck;
  logic       mosi;
  logic       ncs;
  logic       miso;
  logic [2:0] major_mode;
  logic [7:0] conf_word;
  logic [7:0] divisor;
  logic       quiesce;
  logic       busy;
  logic       frame_err;

  modport master (
    output spck, mosi, ncs,
    input  miso, major_mode, conf_word, divisor, quiesce, busy, frame_err
  );

  modport slave (
    input  spck, mosi, ncs,
    output miso, major_mode, conf_word, divisor, quiesce, busy, frame_err
  );
endinterface

// File: rtl/fpga_mode_ctrl.sv
// Receives 16-bit ARM configuration frames over SPI (sampled in the pck0 domain) and
// sequences glitch-free major-mode changes: the muxes are held quiet for GUARD_CYCLES
// before the select switches and SETTLE_CYCLES after it.
// Ports:
//   pck0    system clock, all logic on posedge
//   nreset  asynchronous active-low reset
//   bus     fpga_mode_ctrl_if.slave: SPI pins in, miso/major_mode/conf_word/divisor/
//           quiesce/busy/frame_err out
// Frame: {cmd[3:0], 4'bx, data[7:0]}, MSB first. cmd 1 = conf update, 2 = divisor,
// 3 = mode off (conf update with 8'hE0); anything else is ignored.
// Optional feature: define FPGA_MODE_CTRL_READBACK_EN to shift a status word out on miso;
// otherwise miso is tied low.
module fpga_mode_ctrl #(
  parameter int unsigned GUARD_CYCLES  = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter logic [7:0]  DIV_RESET     = 8'd95
) (
  input logic             pck0,
  input logic             nreset,
  fpga_mode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StQuiesce, StSwitch, StSettle} state_e;

  localparam logic [7:0] GuardLoad   = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0] SettleLoad  = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] ModeOffConf = 8'hE0;

  // Synchronizers and edge detectors
  logic spck_s1, spck_s2, spck_d;
  logic mosi_s1, mosi_s2;
  logic ncs_s1, ncs_s2, ncs_d;
  logic spck_rise, ncs_rise;

  // Frame capture and decoded outputs
  logic [15:0] shift_reg;
  logic [4:0]  bitcnt;
  logic [3:0]  frame_cmd;
  logic [7:0]  frame_data;
  logic        frame_drop;
  logic        conf_req;
  logic [7:0]  conf_data;
  logic        div_req;

  // Mode-switch sequencer
  state_e      state;
  logic [7:0]  cnt;
  logic [7:0]  pending;
  logic [7:0]  pend_nxt;
  logic        settle_done;
  logic [2:0]  major_mode;
  logic [7:0]  conf_word;
  logic [7:0]  divisor;
  logic        quiesce;
  logic        busy;
  logic        frame_err;

  logic unused_frame_pad;
  assign unused_frame_pad = ^shift_reg[11:8];

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      spck_s1 <= 1'b0;
      spck_s2 <= 1'b0;
      spck_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      // ncs idles high; resetting its chain low would fake a frame end after reset.
      ncs_s1  <= 1'b1;
      ncs_s2  <= 1'b1;
      ncs_d   <= 1'b1;
    end else begin
      spck_s1 <= bus.spck;
      spck_s2 <= spck_s1;
      spck_d  <= spck_s2;
      mosi_s1 <= bus.mosi;
      mosi_s2 <= mosi_s1;
      ncs_s1  <= bus.ncs;
      ncs_s2  <= ncs_s1;
      ncs_d   <= ncs_s2;
    end
  end

  assign spck_rise = spck_s2 & ~spck_d;
  assign ncs_rise  = ncs_s2 & ~ncs_d;

  always_comb begin
    frame_cmd   = shift_reg[15:12];
    frame_data  = shift_reg[7:0];
    frame_drop  = ncs_rise && (bitcnt != 5'd16);
    conf_req    = 1'b0;
    conf_data   = frame_data;
    div_req     = 1'b0;
    if (ncs_rise && (bitcnt == 5'd16)) begin
      case (frame_cmd)
        4'h1: conf_req = 1'b1;
        4'h2: div_req = 1'b1;
        4'h3: begin
          conf_req  = 1'b1;
          conf_data = ModeOffConf;
        end
        default: ;
      endcase
    end
    // While a sequence runs, conf frames land in pending and the latest one wins, even
    // when it arrives in the same cycle as a switch or settle-end decision.
    pend_nxt    = (conf_req && (state != StIdle)) ? conf_data : pending;
    settle_done = ((state == StSwitch) && (SETTLE_CYCLES == 0)) ||
                  ((state == StSettle) && (cnt == 8'd0));
  end

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      shift_reg  <= 16'h0000;
      bitcnt     <= 5'd0;
      state      <= StIdle;
      cnt        <= 8'd0;
      pending    <= 8'h00;
      major_mode <= 3'b111;
      conf_word  <= 8'hE0;
      divisor    <= DIV_RESET;
      quiesce    <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= frame_drop;

      // ncs_s2 is already high in the frame-end cycle, so a coincident spck rise is dropped.
      if (ncs_rise) begin
        bitcnt <= 5'd0;
      end else if (spck_rise && !ncs_s2) begin
        shift_reg <= {shift_reg[14:0], mosi_s2};
        if (bitcnt != 5'd17) begin
          bitcnt <= bitcnt + 5'd1;
        end
      end

      if (div_req) begin
        divisor <= frame_data;
      end

      pending <= pend_nxt;

      case (state)
        StIdle: begin
          if (conf_req) begin
            if (conf_data[7:5] == major_mode) begin
              conf_word <= conf_data;
            end else begin
              pending <= conf_data;
              state   <= StQuiesce;
              cnt     <= GuardLoad;
              quiesce <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        StQuiesce: begin
          if (cnt == 8'd0) begin
            state      <= StSwitch;
            major_mode <= pend_nxt[7:5];
            conf_word  <= pend_nxt;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        StSwitch: begin
          if (SETTLE_CYCLES != 0) begin
            state <= StSettle;
            cnt   <= SettleLoad;
          end
        end
        StSettle: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= StIdle;
      endcase

      // A request that arrived mid-sequence for another mode chains straight into a new
      // guard window; otherwise the latest same-mode word is committed and the muxes released.
      if (settle_done) begin
        if (pend_nxt[7:5] != major_mode) begin
          state <= StQuiesce;
          cnt   <= GuardLoad;
        end else begin
          conf_word <= pend_nxt;
          state     <= StIdle;
          quiesce   <= 1'b0;
          busy      <= 1'b0;
        end
      end
    end
  end

`ifdef FPGA_MODE_CTRL_READBACK_EN
  logic        spck_fall, ncs_fall;
  logic [15:0] status_sr;
  logic        frame_err_sticky;

  assign spck_fall = ~spck_s2 & spck_d;
  assign ncs_fall  = ~ncs_s2 & ncs_d;

  always_ff @(posedge pck0 or negedge nreset) begin
    if (!nreset) begin
      status_sr        <= 16'h0000;
      frame_err_sticky <= 1'b0;
    end else if (ncs_fall) begin
      status_sr        <= {busy, frame_err_sticky, 3'b000, major_mode, conf_word};
      frame_err_sticky <= 1'b0;
    end else begin
      if (spck_fall && !ncs_s2) begin
        status_sr <= {status_sr[14:0], 1'b0};
      end
      if (frame_drop) begin
        frame_err_sticky <= 1'b1;
      end
    end
  end

  assign bus.miso = status_sr[15];
`else
  assign bus.miso = 1'b0;
`endif

  assign bus.major_mode = major_mode;
  assign bus.conf_word  = conf_word;
  assign bus.divisor    = divisor;
  assign bus.quiesce    = quiesce;
  assign bus.busy       = busy;
  assign bus.frame_err  = frame_err;

endmodule

// File: tb/tb_fpga_mode_ctrl.sv
// Bench for fpga_mode_ctrl: two instances share the SPI pins, one with the default
// 16/8 guard/settle timing and one with a long guard and no settle phase, so that several
// frames can land inside one guard window. Outputs are compared every cycle against a
// timeline model (sequence start cycle plus elapsed-cycle arithmetic).
module tb_fpga_mode_ctrl;

  localparam int unsigned G0 = 16;
  localparam int unsigned S0 = 8;
  localparam int unsigned G1 = 200;
  localparam int unsigned S1 = 0;

  logic pck0;
  logic nreset;

  fpga_mode_ctrl_if bus0 ();
  fpga_mode_ctrl_if bus1 ();

  assign bus1.spck = bus0.spck;
  assign bus1.mosi = bus0.mosi;
  assign bus1.ncs  = bus0.ncs;

  fpga_mode_ctrl #(.GUARD_CYCLES(G0), .SETTLE_CYCLES(S0), .DIV_RESET(8'd95)) dut0 (
    .pck0   (pck0),
    .nreset (nreset),
    .bus    (bus0)
  );

  fpga_mode_ctrl #(.GUARD_CYCLES(G1), .SETTLE_CYCLES(S1), .DIV_RESET(8'd95)) dut1 (
    .pck0   (pck0),
    .nreset (nreset),
    .bus    (bus1)
  );

  initial pck0 = 1'b0;
  always #5 pck0 = ~pck0;

  logic [21:0] obs0, obs1;
  assign obs0 = {bus0.major_mode, bus0.conf_word, bus0.divisor, bus0.quiesce, bus0.busy,
                 bus0.frame_err};
  assign obs1 = {bus1.major_mode, bus1.conf_word, bus1.divisor, bus1.quiesce, bus1.busy,
                 bus1.frame_err};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model, one slot per instance
  logic [2:0] m_mode   [2];
  logic [7:0] m_conf   [2];
  logic [7:0] m_div    [2];
  logic [7:0] m_pend   [2];
  bit         m_busy   [2];
  bit         m_ferr   [2];
  bit         m_sticky [2];
  int         m_start  [2];

  // Observation helpers
  int          q0_cnt;
  int          frame_cyc;
  int          sw_cyc0;
  logic [2:0]  prev_mode0;
  bit          seen010;
  logic [15:0] last_rd0, last_rd1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int g_of(input int i);
    return (i == 0) ? int'(G0) : int'(G1);
  endfunction

  function automatic int s_of(input int i);
    return (i == 0) ? int'(S0) : int'(S1);
  endfunction

  function automatic logic [21:0] exp_vec(input int i);
    return {m_mode[i], m_conf[i], m_div[i], m_busy[i], m_busy[i], m_ferr[i]};
  endfunction

  function automatic logic [15:0] status_exp(input int i);
`ifdef FPGA_MODE_CTRL_READBACK_EN
    return {m_busy[i], m_sticky[i], 3'b000, m_mode[i], m_conf[i]};
`else
    return 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i]   = 3'b111;
      m_conf[i]   = 8'hE0;
      m_div[i]    = 8'd95;
      m_pend[i]   = 8'h00;
      m_busy[i]   = 1'b0;
      m_ferr[i]   = 1'b0;
      m_sticky[i] = 1'b0;
      m_start[i]  = 0;
    end
  endtask

  // Values visible in cycle 'cyc'; a frame passed here is the one whose end was seen
  // in the previous cycle.
  task automatic model_edge(input int i, input bit fr, input int nb, input logic [15:0] w);
    bit         conf;
    logic [7:0] cd;
    int         ph;
    conf = 1'b0;
    cd   = 8'h00;
    m_ferr[i] = 1'b0;
    if (fr) begin
      if (nb != 16) begin
        m_ferr[i]   = 1'b1;
        m_sticky[i] = 1'b1;
      end else begin
        case (w[15:12])
          4'h1: begin conf = 1'b1; cd = w[7:0]; end
          4'h2: m_div[i] = w[7:0];
          4'h3: begin conf = 1'b1; cd = 8'hE0; end
          default: ;
        endcase
      end
    end
    if (m_busy[i]) begin
      if (conf) m_pend[i] = cd;
      ph = cyc - m_start[i];
      if (ph == g_of(i)) begin
        m_mode[i] = m_pend[i][7:5];
        m_conf[i] = m_pend[i];
      end
      if (ph == g_of(i) + 1 + s_of(i)) begin
        if (m_pend[i][7:5] != m_mode[i]) begin
          m_start[i] = cyc;
        end else begin
          m_conf[i] = m_pend[i];
          m_busy[i] = 1'b0;
        end
      end
    end else if (conf) begin
      if (cd[7:5] == m_mode[i]) begin
        m_conf[i] = cd;
      end else begin
        m_pend[i]  = cd;
        m_busy[i]  = 1'b1;
        m_start[i] = cyc;
      end
    end
  endtask

  task automatic step(input bit fr, input int nb, input logic [15:0] w);
    @(posedge pck0);
    cyc++;
    if (nreset) begin
      for (int i = 0; i < 2; i++) model_edge(i, fr, nb, w);
    end
    if (fr) frame_cyc = cyc;
    @(negedge pck0);
    if (bus0.quiesce) q0_cnt++;
    if (bus1.major_mode == 3'b010) seen010 = 1'b1;
    if ((bus0.major_mode !== prev_mode0) && (sw_cyc0 < 0)) sw_cyc0 = cyc;
    prev_mode0 = bus0.major_mode;
    chk("outputs0", 32'(obs0), 32'(exp_vec(0)));
    chk("outputs1", 32'(obs1), 32'(exp_vec(1)));
  endtask

  task automatic tick();
    step(1'b0, 0, 16'h0000);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // nb spck pulses; spck period is 4 pck0 cycles. Returns at the cycle after frame end.
  task automatic send_frame(input int nb, input logic [15:0] w);
    logic [31:0] ww;
    logic [15:0] snap0, snap1;
    ww = {w, w};
    snap0 = 16'h0;
    snap1 = 16'h0;
    last_rd0 = 16'h0;
    last_rd1 = 16'h0;
    bus0.ncs = 1'b0;
    for (int k = 0; k < nb; k++) begin
      bus0.mosi = ww[31-k];
      tick();
      tick();
      if (k == 0) begin
        // Status is captured from the values of the ncs-fall cycle, which clears sticky.
        snap0 = status_exp(0);
        snap1 = status_exp(1);
        m_sticky[0] = 1'b0;
        m_sticky[1] = 1'b0;
      end
      bus0.spck = 1'b1;
      tick();
      tick();
      if (k < 16) begin
        last_rd0[15-k] = bus0.miso;
        last_rd1[15-k] = bus1.miso;
      end
      bus0.spck = 1'b0;
    end
    tick();
    tick();
    bus0.ncs = 1'b1;
    tick();
    tick();
    step(1'b1, nb, w);
    if (nb >= 16) begin
      chk("status0", 32'(last_rd0), 32'(snap0));
      chk("status1", 32'(last_rd1), 32'(snap1));
    end
  endtask

  initial begin
    int          r;
    logic [3:0]  cmd;
    logic [15:0] w;
    int          nb;

    nreset    = 1'b1;
    bus0.spck = 1'b0;
    bus0.mosi = 1'b0;
    bus0.ncs  = 1'b1;
    sw_cyc0   = -1;
    q0_cnt    = 0;
    seen010   = 1'b0;
    frame_cyc = 0;
    prev_mode0 = 3'b111;
    model_reset();
    #2 nreset = 1'b0;
    ticks(3);
    chk("reset_mode", 32'(bus0.major_mode), 32'h7);
    chk("reset_conf", 32'(bus0.conf_word), 32'hE0);
    chk("reset_div", 32'(bus0.divisor), 32'd95);
    chk("reset_miso", 32'(bus0.miso), 32'h0);
    nreset = 1'b1;
    ticks(4);

    // Mode 001 from reset: 25-cycle quiesce, switch 16 cycles after d+1
    q0_cnt  = 0;
    sw_cyc0 = -1;
    send_frame(16, 16'h1020);
    chk("quiesce_start", 32'(bus0.quiesce), 32'h1);
    ticks(40);
    chk("quiesce_width", 32'(q0_cnt), 32'd25);
    chk("switch_delay", 32'(sw_cyc0 - frame_cyc), 32'd16);
    chk("conf_after_switch", 32'(bus0.conf_word), 32'h20);
    ticks(int'(G1) + 5);

    // Same-mode conf update is immediate
    send_frame(16, 16'h1021);
    chk("conf_same_mode", 32'(bus0.conf_word), 32'h21);
    chk("no_quiesce_same_mode", 32'(bus0.quiesce), 32'h0);

    // Long-guard instance: 010, divisor, 011 all inside one guard window
    seen010 = 1'b0;
    send_frame(16, 16'h1040);
    send_frame(16, 16'h2017);
    chk("div_during_quiesce", 32'(bus1.divisor), 32'h17);
    chk("still_quiesced", 32'(bus1.quiesce), 32'h1);
    send_frame(16, 16'h1060);
    ticks(int'(G1) + 20);
    chk("latest_mode_wins", 32'(bus1.major_mode), 32'h3);
    chk("mode010_never_seen", 32'(seen010), 32'h0);

    // Bad bit counts
    send_frame(15, 16'h1080);
    chk("frame_err_15", 32'(bus0.frame_err), 32'h1);
    tick();
    send_frame(17, 16'h1080);
    chk("frame_err_17", 32'(bus0.frame_err), 32'h1);
    tick();
    chk("frame_err_pulse", 32'(bus0.frame_err), 32'h0);

    // Mode off, then status read while busy
    send_frame(16, 16'h3000);
    ticks(int'(G1) + 5);
    send_frame(16, 16'h10C0);
    send_frame(16, 16'h0000);
`ifdef FPGA_MODE_CTRL_READBACK_EN
    chk("status_busy_bit", 32'(last_rd0[15]), 32'h1);
`endif
    ticks(int'(G1) + 5);

    // Reset in the settle phase
    send_frame(16, 16'h10A0);
    ticks(int'(G0) + 3);
    nreset = 1'b0;
    #1;
    chk("async_reset_mode", 32'(bus0.major_mode), 32'h7);
    chk("async_reset_quiesce", 32'(bus0.quiesce), 32'h0);
    chk("async_reset_busy", 32'(bus0.busy), 32'h0);
    model_reset();
    prev_mode0 = 3'b111;
    ticks(2);
    nreset = 1'b1;
    ticks(3);

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 6));
      case (r)
        0: cmd = 4'h0;
        1, 2, 3: cmd = 4'h1;
        4: cmd = 4'h2;
        5: cmd = 4'h3;
        default: cmd = 4'h5;
      endcase
      w = {cmd, 4'h0, 8'($urandom)};
      r = int'($urandom_range(0, 99));
      nb = (r < 8) ? 15 : ((r < 16) ? 17 : 16);
      send_frame(nb, w);
      ticks(int'($urandom_range(0, 40)));
    end
    ticks(int'(G1) + 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
